// File: rtl/bus6509_pkg.sv
// Shared types and constants for the 6509 CPU bus controller.
// Bus-cycle state encoding, reset execution bank and timer width.
package bus6509_pkg;

  typedef enum logic [2:0] {
    ST_P1,
    ST_GAP1,
    ST_P2,
    ST_WAIT,
    ST_GAP2
  } state_t;

  localparam logic [3:0] BANK_RESET = 4'hF;
  localparam int         ADDR_W     = 20;
  localparam int         TMR_W      = 8;

endpackage

// File: rtl/bus6509_ctrl_if.sv
// CPU-side and memory-side signals of the 6509 bus, grouped for the controller.
// master = bus6509_ctrl; slave = CPU/memory model side.
interface bus6509_ctrl_if;
  import bus6509_pkg::*;

  logic              phi1_6509;
  logic              phi2_6509;
  logic [3:0]        address_bank;
  logic [15:0]       address_cpu;
  logic              r_w;
  logic              sync;
  logic              dma_req;
  logic              rdy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_oe;
  logic              mem_we;
  logic              mem_ack;
  logic              bank_xfer;
  logic              wait_timeout;

  modport master (
    output phi1_6509, phi2_6509, rdy, mem_addr, mem_req, mem_oe, mem_we,
           bank_xfer, wait_timeout,
    input  address_bank, address_cpu, r_w, sync, dma_req, mem_ack
  );

  modport slave (
    input  phi1_6509, phi2_6509, rdy, mem_addr, mem_req, mem_oe, mem_we,
           bank_xfer, wait_timeout,
    output address_bank, address_cpu, r_w, sync, dma_req, mem_ack
  );

endinterface

// File: rtl/bus6509_ctrl_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Load takes effect on the next clock; the count holds at zero until reloaded.
module bus6509_ctrl_phase_timer
  import bus6509_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             tc
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bus6509_ctrl.sv
// System-side master of the 6509 bus: phi1/phi2 generation, memory request, bank snoop, DMA rdy.
// Period P1+GAP+P2+GAP clocks; with BUS6509_WAIT_EN defined, phi2 stretches until mem_ack or MAX_WAIT.
// rdy follows dma_req sampled on the last GAP2 clock, updated only at P1 entry.
module bus6509_ctrl
  import bus6509_pkg::*;
#(
  parameter int P1_CLKS  = 4,
  parameter int P2_CLKS  = 4,
  parameter int GAP_CLKS = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic           clock,
  input  logic           _reset,
  bus6509_ctrl_if.master bus
);

  state_t           state, state_nxt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             timeout_nxt;
  logic [3:0]       exec_bank;
  logic             p2_entry;
  logic             bus_exit;

  bus6509_ctrl_phase_timer #(
    .RST_VAL (TMR_W'(P1_CLKS - 1))
  ) u_timer (
    .clock    (clock),
    ._reset   (_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nxt   = state;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    timeout_nxt = 1'b0;
    case (state)
      ST_P1: if (tmr_tc) begin
        state_nxt = ST_GAP1;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(GAP_CLKS - 1);
      end
      ST_GAP1: if (tmr_tc) begin
        state_nxt = ST_P2;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(P2_CLKS - 1);
      end
      ST_P2: if (tmr_tc) begin
        state_nxt = ST_GAP2;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(GAP_CLKS - 1);
`ifdef BUS6509_WAIT_EN
        // an ack on the final P2 clock already satisfies the request
        if (bus.mem_req && !bus.mem_ack) begin
          state_nxt = ST_WAIT;
          tmr_val   = TMR_W'(MAX_WAIT - 1);
        end
`endif
      end
      ST_WAIT: if (bus.mem_ack || tmr_tc) begin
        state_nxt = ST_GAP2;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(GAP_CLKS - 1);
`ifdef BUS6509_WAIT_EN
        timeout_nxt = !bus.mem_ack;
`endif
      end
      ST_GAP2: if (tmr_tc) begin
        state_nxt = ST_P1;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(P1_CLKS - 1);
      end
      default: begin
        state_nxt = ST_P1;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(P1_CLKS - 1);
      end
    endcase
  end

  assign p2_entry = (state == ST_GAP1) && tmr_tc;
  assign bus_exit = ((state == ST_P2) || (state == ST_WAIT)) && (state_nxt == ST_GAP2);

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state            <= ST_P1;
      bus.phi1_6509    <= 1'b1;
      bus.phi2_6509    <= 1'b0;
      bus.rdy          <= 1'b1;
      bus.mem_req      <= 1'b0;
      bus.mem_oe       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.bank_xfer    <= 1'b0;
      bus.wait_timeout <= 1'b0;
      exec_bank        <= BANK_RESET;
    end else begin
      state            <= state_nxt;
      // phases decoded from the next state so both outputs come straight off flops
      bus.phi1_6509    <= (state_nxt == ST_P1);
      bus.phi2_6509    <= (state_nxt == ST_P2) || (state_nxt == ST_WAIT);
      bus.wait_timeout <= timeout_nxt;

      if (p2_entry) begin
        bus.mem_addr  <= {bus.address_bank, bus.address_cpu};
        bus.mem_req   <= 1'b1;
        bus.mem_oe    <= bus.r_w;
        bus.mem_we    <= !bus.r_w;
        bus.bank_xfer <= !bus.sync && (bus.address_bank != exec_bank);
        if (bus.sync) begin
          exec_bank <= bus.address_bank;
        end
      end else if (bus_exit || (bus.mem_req && bus.mem_ack)) begin
        bus.mem_req <= 1'b0;
        bus.mem_oe  <= 1'b0;
        bus.mem_we  <= 1'b0;
      end

      if ((state == ST_GAP2) && tmr_tc) begin
        bus.rdy <= !bus.dma_req;
      end
    end
  end

endmodule

// File: tb/tb_bus6509_ctrl.sv
// Bench for bus6509_ctrl: each bus cycle is planned up front (ack clock, latched inputs, DMA)
// and every clock is checked against the expected phase position within that cycle.
module tb_bus6509_ctrl;

  localparam int P1  = 4;
  localparam int P2  = 4;
  localparam int GAP = 1;
  localparam int MW  = 15;

  logic clock  = 1'b0;
  logic _reset = 1'b0;
  always #5 clock = ~clock;

  bus6509_ctrl_if bus ();

  bus6509_ctrl #(
    .P1_CLKS  (P1),
    .P2_CLKS  (P2),
    .GAP_CLKS (GAP),
    .MAX_WAIT (MW)
  ) dut (
    .clock  (clock),
    ._reset (_reset),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // expected bus-visible state carried between cycles
  logic [3:0]  m_exec = 4'hF;
  logic        m_rdy  = 1'b1;
  logic [19:0] m_addr = '0;
  logic        m_xfer = 1'b0;
  logic        m_rw   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_inputs();
    bus.address_bank = 4'($urandom);
    bus.address_cpu  = 16'($urandom);
    bus.r_w          = 1'($urandom);
    bus.sync         = 1'($urandom);
    bus.dma_req      = 1'($urandom);
    bus.mem_ack      = 1'($urandom);
  endtask

  task automatic check_outputs(input string ph, input logic e_phi1, input logic e_phi2,
                               input logic e_req, input logic e_to);
    check_eq({ph, ".phi1"},   32'(bus.phi1_6509), 32'(e_phi1));
    check_eq({ph, ".phi2"},   32'(bus.phi2_6509), 32'(e_phi2));
    check_eq({ph, ".overlap"}, 32'(bus.phi1_6509 & bus.phi2_6509), 32'd0);
    check_eq({ph, ".rdy"},    32'(bus.rdy), 32'(m_rdy));
    check_eq({ph, ".req"},    32'(bus.mem_req), 32'(e_req));
    check_eq({ph, ".oe"},     32'(bus.mem_oe), 32'(e_req & m_rw));
    check_eq({ph, ".we"},     32'(bus.mem_we), 32'(e_req & ~m_rw));
    check_eq({ph, ".addr"},   32'(bus.mem_addr), 32'(m_addr));
    check_eq({ph, ".xfer"},   32'(bus.bank_xfer), 32'(m_xfer));
    check_eq({ph, ".tmo"},    32'(bus.wait_timeout), 32'(e_to));
  endtask

  // called just after a rising edge: sample at the falling edge, return just after the next rise
  task automatic step(input string ph, input logic e_phi1, input logic e_phi2,
                      input logic e_req, input logic e_to);
    @(negedge clock);
    check_outputs(ph, e_phi1, e_phi2, e_req, e_to);
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_exec = 4'hF;
    m_rdy  = 1'b1;
    m_addr = '0;
    m_xfer = 1'b0;
    m_rw   = 1'b0;
  endtask

  // ack_at: phi2 clock (1-based) from which mem_ack is held high; 0 = never.
  // abort_at: phi2 clock at which _reset is pulsed; 0 = none.
  task automatic run_cycle(input int ack_at, input int abort_at, input logic [3:0] bank,
                           input logic [15:0] addr, input logic sy, input logic rw,
                           input logic dma);
    int   len;
    logic tmo;
    for (int p = 0; p < P1; p++) begin
      rand_inputs();
      step("p1", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int g = 0; g < GAP; g++) begin
      rand_inputs();
      if (g == GAP - 1) begin
        bus.address_bank = bank;
        bus.address_cpu  = addr;
        bus.sync         = sy;
        bus.r_w          = rw;
      end
      step("gap1", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    m_addr = {bank, addr};
    m_rw   = rw;
    m_xfer = !sy && (bank != m_exec);
    if (sy) m_exec = bank;

    len = P2;
    tmo = 1'b0;
`ifdef BUS6509_WAIT_EN
    if (ack_at == 0 || ack_at > P2 + MW) begin
      len = P2 + MW;
      tmo = 1'b1;
    end else if (ack_at > P2) begin
      len = ack_at;
    end
`endif
    for (int k = 1; k <= len; k++) begin
      rand_inputs();
      bus.mem_ack = (ack_at != 0) && (k >= ack_at);
      if (k == abort_at) begin
        _reset = 1'b0;
        #1;
        model_reset();
        check_outputs("abort", 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        _reset = 1'b1;
        return;
      end
      step("p2", 1'b0, 1'b1, (ack_at == 0) || (k <= ack_at), 1'b0);
    end
    for (int g = 0; g < GAP; g++) begin
      rand_inputs();
      if (g == GAP - 1) bus.dma_req = dma;
      step("gap2", 1'b0, 1'b0, 1'b0, tmo && (g == 0));
    end
    m_rdy = !dma;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int abort_k;
    rand_inputs();
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    _reset = 1'b1;

    // ack effectively tied high: nominal 10-clock period
    repeat (3) run_cycle(1, 0, 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // bank snooping: fetch from bank 3, then a data cycle in bank 5
    run_cycle(1, 0, 4'h3, 16'h1234, 1'b1, 1'b1, 1'b0);
    check_eq("snoop.addr", 32'(bus.mem_addr), 32'h31234);
    check_eq("snoop.xfer0", 32'(bus.bank_xfer), 32'd0);
    run_cycle(2, 0, 4'h5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check_eq("snoop.xfer1", 32'(bus.bank_xfer), 32'd1);
    run_cycle(3, 0, 4'h3, 16'h0042, 1'b0, 1'b1, 1'b0);

    // late ack and no ack
    run_cycle(6, 0, 4'h3, 16'h0100, 1'b0, 1'b1, 1'b0);
    run_cycle(0, 0, 4'h3, 16'h0200, 1'b0, 1'b0, 1'b0);
    run_cycle(P2, 0, 4'h3, 16'h0300, 1'b0, 1'b1, 1'b0);
    run_cycle(P2 + MW, 0, 4'h3, 16'h0400, 1'b0, 1'b1, 1'b0);

    // DMA request gating rdy
    run_cycle(2, 0, 4'h1, 16'h0500, 1'b1, 1'b1, 1'b1);
    run_cycle(2, 0, 4'h1, 16'h0600, 1'b0, 1'b1, 1'b1);
    run_cycle(2, 0, 4'h1, 16'h0700, 1'b0, 1'b1, 1'b0);

    // reset in the middle of a stretched (or plain) phi2
`ifdef BUS6509_WAIT_EN
    abort_k = P2 + 4;
`else
    abort_k = P2 - 1;
`endif
    run_cycle(0, abort_k, 4'h2, 16'h0800, 1'b1, 1'b0, 1'b1);
    run_cycle(1, 0, 4'hF, 16'h0900, 1'b0, 1'b1, 1'b0);
    check_eq("post_reset.xfer_f", 32'(bus.bank_xfer), 32'd0);
    run_cycle(1, 0, 4'h2, 16'h0A00, 1'b0, 1'b1, 1'b0);
    check_eq("post_reset.xfer_2", 32'(bus.bank_xfer), 32'd1);

    for (int i = 0; i < 40; i++) begin
      run_cycle(int'($urandom_range(0, P2 + MW + 3)),
                (($urandom_range(0, 19) == 0) ? 1 : 0),
                4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
